flag_branch_unit: RTL and testbench

- Consumer end of the ALU status path: latches N/Z/C/V produced by the ALU and its 64-bit zero-detect tree on flag-setting instructions.
- Evaluates branch conditions (B, CBZ, B.cond) to drive the PC-select mux of the single-cycle CPU.
- Keeps a saturating taken-branch counter for lab performance reporting.

---
 rtl/flag_branch_unit.sv | 93 +++++++++
 tb/tb_flag_branch_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// NZCV flag register and branch-condition evaluator driving the PC-select mux,
// plus a saturating taken-branch counter for performance reporting.
module flag_branch_unit #(
  parameter bit FORWARD = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             set_flags,
  input  logic [1:0]       branch_type,
  input  logic [3:0]       cond_sel,
  output logic [3:0]       flags_q,
  output logic             take_branch,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [1:0] BR_NONE   = 2'b00;
  localparam logic [1:0] BR_UNCOND = 2'b01;
  localparam logic [1:0] BR_CBZ    = 2'b10;
  localparam logic [1:0] BR_COND   = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       cond_met;

  assign alu_flags = {alu_negative, alu_zero, alu_carry, alu_overflow};

  // Forwarding lets a B.cond fused with a flag-setting op see the new flags.
  assign eff_flags = (FORWARD && set_flags) ? alu_flags : flags_q;
  assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

  always_comb begin
    cond_met = 1'b0;
    case (cond_sel)
      4'h0: cond_met = flag_z;
      4'h1: cond_met = !flag_z;
      4'h2: cond_met = flag_c;
      4'h3: cond_met = !flag_c;
      4'h4: cond_met = flag_n;
      4'h5: cond_met = !flag_n;
      4'h6: cond_met = flag_v;
      4'h7: cond_met = !flag_v;
      4'h8: cond_met = flag_c && !flag_z;
      4'h9: cond_met = !flag_c || flag_z;
      4'hA: cond_met = (flag_n == flag_v);
      4'hB: cond_met = (flag_n != flag_v);
      4'hC: cond_met = !flag_z && (flag_n == flag_v);
      4'hD: cond_met = flag_z || (flag_n != flag_v);
      default: cond_met = 1'b1;
    endcase
  end

  // CBZ looks only at the current operand's zero detect, never at flags_q.
  always_comb begin
    take_branch = 1'b0;
    case (branch_type)
      BR_NONE:   take_branch = 1'b0;
      BR_UNCOND: take_branch = 1'b1;
      BR_CBZ:    take_branch = alu_zero;
      BR_COND:   take_branch = cond_met;
      default:   take_branch = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (!stall && set_flags) begin
      flags_q <= alu_flags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_count <= '0;
    end else if (!stall && take_branch && (taken_count != CNT_MAX)) begin
      taken_count <= taken_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit: one instance per
// parameter set of interest (forwarding on/off, narrow saturating counter).
`timescale 1ns/1ps
module tb_flag_branch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        alu_negative;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_overflow;
  logic        set_flags;
  logic [1:0]  branch_type;
  logic [3:0]  cond_sel;

  logic [3:0]  flags_fw;
  logic        take_fw;
  logic [15:0] count_fw;
  logic [3:0]  flags_nf;
  logic        take_nf;
  logic [15:0] count_nf;
  logic [3:0]  flags_sat;
  logic        take_sat;
  logic [3:0]  count_sat;

  int errors;
  int checks;

  flag_branch_unit #(.FORWARD(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .branch_type(branch_type), .cond_sel(cond_sel),
    .flags_q(flags_fw), .take_branch(take_fw), .taken_count(count_fw)
  );

  flag_branch_unit #(.FORWARD(1'b0), .CNT_W(16)) dut_nf (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .branch_type(branch_type), .cond_sel(cond_sel),
    .flags_q(flags_nf), .take_branch(take_nf), .taken_count(count_nf)
  );

  flag_branch_unit #(.FORWARD(1'b1), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .set_flags(set_flags), .branch_type(branch_type), .cond_sel(cond_sel),
    .flags_q(flags_sat), .take_branch(take_sat), .taken_count(count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns (1000 ps) past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [3:0] nzcv);
    {alu_negative, alu_zero, alu_carry, alu_overflow} = nzcv;
  endtask

  task automatic load_flags(input logic [3:0] nzcv);
    set_alu(nzcv);
    set_flags   = 1'b1;
    branch_type = 2'b00;
    tick();
    set_flags   = 1'b0;
    set_alu(4'b0000);
  endtask

  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    reset = 1'b1;
    #1;
    checks++;
    if (flags_fw !== 4'b0000) begin
      errors++; $display("[TB] FAIL por_flags got=%b exp=0000", flags_fw);
    end
    checks++;
    if (count_fw !== 16'd0) begin
      errors++; $display("[TB] FAIL por_count got=%0d exp=0", count_fw);
    end
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL por_take got=%b exp=0", take_fw);
    end
    @(negedge clk);
    reset = 1'b0;
    load_flags(4'b1111);
    branch_type = 2'b01;
    repeat (5) tick();
    branch_type = 2'b00;
    #1;
    checks++;
    if (flags_fw !== 4'b1111) begin
      errors++; $display("[TB] FAIL preset_flags got=%b exp=1111", flags_fw);
    end
    checks++;
    if (count_fw !== 16'd5) begin
      errors++; $display("[TB] FAIL preset_count got=%0d exp=5", count_fw);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (flags_fw !== 4'b0000) begin
      errors++; $display("[TB] FAIL async_flags got=%b exp=0000", flags_fw);
    end
    checks++;
    if (count_fw !== 16'd0) begin
      errors++; $display("[TB] FAIL async_count got=%0d exp=0", count_fw);
    end
    reset = 1'b0;
    branch_type = 2'b01;
    tick();
    branch_type = 2'b00;
    checks++;
    if (count_fw !== 16'd1) begin
      errors++; $display("[TB] FAIL first_edge_count got=%0d exp=1", count_fw);
    end
  endtask

  task automatic test_subs_equal();
    $display("[TB] test_subs_equal");
    load_flags(4'b0100);
    branch_type = 2'b11;
    cond_sel    = 4'h0;
    #1;
    checks++;
    if (flags_fw !== 4'b0100) begin
      errors++; $display("[TB] FAIL subs_flags got=%b exp=0100", flags_fw);
    end
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL subs_eq got=%b exp=1", take_fw);
    end
    cond_sel = 4'h1;
    #1;
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL subs_ne got=%b exp=0", take_fw);
    end
    branch_type = 2'b00;
  endtask

  task automatic test_signed_compare();
    $display("[TB] test_signed_compare");
    load_flags(4'b1000);
    branch_type = 2'b11;
    cond_sel = 4'hB;
    #1;
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL lt_n got=%b exp=1", take_fw);
    end
    cond_sel = 4'hA;
    #1;
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL ge_n got=%b exp=0", take_fw);
    end
    cond_sel = 4'hC;
    #1;
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL gt_n got=%b exp=0", take_fw);
    end
    branch_type = 2'b00;
    load_flags(4'b1001);
    branch_type = 2'b11;
    cond_sel = 4'hC;
    #1;
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL gt_nv got=%b exp=1", take_fw);
    end
    branch_type = 2'b00;
  endtask

  // Full condition tables for two flag patterns; bit i is the result for cond i.
  task automatic test_cond_table();
    logic [3:0]  pats [2];
    logic [15:0] exps [2];
    logic [15:0] exp_vec;
    $display("[TB] test_cond_table");
    pats[0] = 4'b0010; exps[0] = 16'hD5A6;
    pats[1] = 4'b1100; exps[1] = 16'hEA99;
    for (int p = 0; p < 2; p++) begin
      load_flags(pats[p]);
      exp_vec = exps[p];
      branch_type = 2'b11;
      for (int c = 0; c < 16; c++) begin
        cond_sel = c[3:0];
        #1;
        checks++;
        if (take_fw !== exp_vec[c]) begin
          errors++;
          $display("[TB] FAIL cond_table flags=%b cond=%0h got=%b exp=%b",
                   pats[p], c, take_fw, exp_vec[c]);
        end
      end
      branch_type = 2'b00;
    end
  endtask

  task automatic test_forwarding();
    $display("[TB] test_forwarding");
    load_flags(4'b0000);
    set_alu(4'b0100);
    set_flags   = 1'b1;
    branch_type = 2'b11;
    cond_sel    = 4'h0;
    #1;
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL fwd_on got=%b exp=1", take_fw);
    end
    checks++;
    if (take_nf !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_off got=%b exp=0", take_nf);
    end
    tick();
    set_flags   = 1'b0;
    branch_type = 2'b00;
    set_alu(4'b0000);
    checks++;
    if (flags_fw !== 4'b0100) begin
      errors++; $display("[TB] FAIL fwd_on_flags got=%b exp=0100", flags_fw);
    end
    checks++;
    if (flags_nf !== 4'b0100) begin
      errors++; $display("[TB] FAIL fwd_off_flags got=%b exp=0100", flags_nf);
    end
    branch_type = 2'b11;
    #1;
    checks++;
    if (take_nf !== 1'b1) begin
      errors++; $display("[TB] FAIL fwd_off_next got=%b exp=1", take_nf);
    end
    branch_type = 2'b00;
  endtask

  task automatic test_cbz();
    $display("[TB] test_cbz");
    load_flags(4'b0100);
    branch_type = 2'b10;
    alu_zero    = 1'b0;
    #1;
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL cbz_nz got=%b exp=0", take_fw);
    end
    branch_type = 2'b00;
    load_flags(4'b0000);
    branch_type = 2'b10;
    alu_zero    = 1'b1;
    #1;
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL cbz_z got=%b exp=1", take_fw);
    end
    branch_type = 2'b00;
    alu_zero    = 1'b0;
  endtask

  task automatic test_stall();
    $display("[TB] test_stall");
    pulse_reset();
    stall       = 1'b1;
    set_flags   = 1'b1;
    set_alu(4'b1111);
    branch_type = 2'b01;
    repeat (3) tick();
    checks++;
    if (take_fw !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_take got=%b exp=1", take_fw);
    end
    checks++;
    if (count_fw !== 16'd0) begin
      errors++; $display("[TB] FAIL stall_count got=%0d exp=0", count_fw);
    end
    checks++;
    if (flags_fw !== 4'b0000) begin
      errors++; $display("[TB] FAIL stall_flags got=%b exp=0000", flags_fw);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (count_fw !== 16'd1) begin
      errors++; $display("[TB] FAIL unstall_count got=%0d exp=1", count_fw);
    end
    checks++;
    if (flags_fw !== 4'b1111) begin
      errors++; $display("[TB] FAIL unstall_flags got=%b exp=1111", flags_fw);
    end
    set_flags   = 1'b0;
    branch_type = 2'b00;
    set_alu(4'b0000);
  endtask

  task automatic test_saturation();
    int exp_sat;
    $display("[TB] test_saturation");
    pulse_reset();
    branch_type = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_sat = (i > 15) ? 15 : i;
      checks++;
      if (count_sat !== exp_sat[3:0]) begin
        errors++;
        $display("[TB] FAIL sat_count step=%0d got=%0d exp=%0d", i, count_sat, exp_sat);
      end
    end
    checks++;
    if (count_fw !== 16'd20) begin
      errors++; $display("[TB] FAIL wide_count got=%0d exp=20", count_fw);
    end
    branch_type = 2'b00;
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    set_flags   = 1'b1;
    set_alu(4'b0010);
    branch_type = 2'b00;
    tick();
    set_alu(4'b1000);
    branch_type = 2'b11;
    cond_sel    = 4'h2;
    #1;
    checks++;
    if (take_nf !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_nf_old got=%b exp=1", take_nf);
    end
    checks++;
    if (take_fw !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_fw_new got=%b exp=0", take_fw);
    end
    tick();
    set_flags   = 1'b0;
    branch_type = 2'b00;
    checks++;
    if (flags_nf !== 4'b1000) begin
      errors++; $display("[TB] FAIL b2b_flags got=%b exp=1000", flags_nf);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    stall = 1'b0;
    set_flags = 1'b0;
    branch_type = 2'b00;
    cond_sel = 4'h0;
    set_alu(4'b0000);
    test_reset();
    test_subs_equal();
    test_signed_compare();
    test_cond_table();
    test_forwarding();
    test_cbz();
    test_stall();
    test_saturation();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
